// File: rtl/gaussian_nb_mul_arbiter_if.sv
// Bundles the requester operand ports, the shared multiplier and the result
// channel of the Gaussian NB multiplier arbiter.
interface gaussian_nb_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*24-1:0] req_b;
  logic                  mul_ce;
  logic signed [15:0]    mul_din0;
  logic signed [23:0]    mul_din1;
  logic signed [39:0]    mul_dout;
  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic signed [39:0]    res_data;
  logic                  busy;

  // slave: the arbiter itself; master: requesters, multiplier and result sink
  modport slave (
    input  req_valid, req_a, req_b, mul_dout, res_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_dout, res_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/gaussian_nb_mul_arbiter.sv
// Round-robin arbiter sharing one ce-stalled pipelined 16s x 24s multiplier;
// a tag pipeline tracks each in-flight product and returns it with its id.
module gaussian_nb_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = 3
) (
  input logic clk,
  input logic reset,
  gaussian_nb_mul_arbiter_if.slave bus
);
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        win_id;
  logic                   win_found;
  logic                   mul_ce;
  int                     cand;
  logic [MUL_LATENCY-1:0] tag_vld_p;
  logic [ID_W-1:0]        tag_id_p [MUL_LATENCY];
  logic signed [15:0]     din0_p0;
  logic signed [23:0]     din1_p0;

  // A held result freezes the whole multiplier pipeline
  assign mul_ce = ~(tag_vld_p[MUL_LATENCY-1] & ~bus.res_ready);

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    if (mul_ce) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = (int'(last_grant) + k) % NUM_REQ;
        if (!win_found && bus.req_valid[cand[ID_W-1:0]]) begin
          win_found = 1'b1;
          win_id    = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    din0_p0       = '0;
    din1_p0       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_found && (win_id == ID_W'(i))) begin
        bus.req_ready[i] = 1'b1;
        din0_p0          = bus.req_a[16*i +: 16];
        din1_p0          = bus.req_b[24*i +: 24];
      end
    end
  end

  // Stage p0 (operands into multiplier) -> tag stages p1..pMUL_LATENCY
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      tag_vld_p  <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id_p[s] <= '0;
    end else if (mul_ce) begin
      tag_vld_p[0] <= win_found;
      tag_id_p[0]  <= win_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_id_p[s]  <= tag_id_p[s-1];
      end
      if (win_found) last_grant <= win_id;
    end
  end

  assign bus.mul_ce    = mul_ce;
  assign bus.mul_din0  = din0_p0;
  assign bus.mul_din1  = din1_p0;
  assign bus.res_valid = tag_vld_p[MUL_LATENCY-1];
  assign bus.res_id    = tag_id_p[MUL_LATENCY-1];
  assign bus.res_data  = bus.mul_dout;
  assign bus.busy      = |tag_vld_p;
endmodule

// File: tb/tb_gaussian_nb_mul_arbiter.sv
// Directed bench for gaussian_nb_mul_arbiter with a 3-stage ce-stalled
// multiplier model standing in for the external multiplier.
module tb_gaussian_nb_mul_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  gaussian_nb_mul_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  gaussian_nb_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LATENCY(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [39:0] mp [3];
  always_ff @(posedge clk) begin
    if (bus.mul_ce) begin
      mp[0] <= 40'(bus.mul_din0) * 40'(bus.mul_din1);
      mp[1] <= mp[0];
      mp[2] <= mp[1];
    end
  end
  assign bus.mul_dout = mp[2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[16*i +: 16] = 16'(a);
    bus.req_b[24*i +: 24] = 24'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();
    #1;
    vectors++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got %0d want 0", bus.res_id); end
    vectors++; if (bus.mul_ce !== 1'b1) begin errors++; $display("FAIL reset_mul_ce got %b want 1", bus.mul_ce); end
    vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    vectors++; if (bus.mul_din0 !== 16'sd0 || bus.mul_din1 !== 24'sd0) begin errors++; $display("FAIL idle_operands got %0d,%0d want 0,0", bus.mul_din0, bus.mul_din1); end
  endtask

  task automatic test_single();
    set_op(0, 3, -5);
    bus.req_valid = 4'b0001;
    #1;
    vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", bus.req_ready); end
    vectors++; if (bus.mul_din0 !== 16'sd3 || bus.mul_din1 !== -24'sd5) begin errors++; $display("FAIL single_operands got %0d,%0d want 3,-5", bus.mul_din0, bus.mul_din1); end
    tick();
    bus.req_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy t+%0d got %b want 1", c, bus.busy); end
      vectors++; if (bus.res_valid !== (c == 3)) begin errors++; $display("FAIL single_res_valid t+%0d got %b want %b", c, bus.res_valid, (c == 3)); end
      tick();
    end
    // Sample of the t+3 result happened before the last tick; re-check data via fresh op below
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_drain busy=%b res_valid=%b want 0,0", bus.busy, bus.res_valid); end
  endtask

  task automatic test_single_data();
    do_reset();
    set_op(0, 3, -5);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0) begin errors++; $display("FAIL single_result valid=%b id=%0d want 1,0", bus.res_valid, bus.res_id); end
    vectors++; if (bus.res_data !== 40'hFFFFFFFFF1) begin errors++; $display("FAIL single_data got %h want fffffffff1", bus.res_data); end
    tick();
  endtask

  task automatic test_round_robin();
    int  ta [8] = '{100, -200, 300, -400, 5, -6, 32767, -32768};
    int  tb_ [8] = '{7, 11, -13, -17, 1000000, -1000000, 2, 3};
    longint ex [8];
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c < 8) begin
        set_op(c % 4, ta[c], tb_[c]);
        ex[c] = longint'(ta[c]) * longint'(tb_[c]);
        bus.req_valid = 4'hF;
      end else begin
        bus.req_valid = '0;
      end
      #1;
      if (c < 8) begin
        vectors++; if (bus.req_ready !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, bus.req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 3) begin
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'((c - 3) % 4)) begin errors++; $display("FAIL rr_result c=%0d valid=%b id=%0d want 1,%0d", c, bus.res_valid, bus.res_id, (c - 3) % 4); end
        vectors++; if (bus.res_data !== 40'(ex[c-3])) begin errors++; $display("FAIL rr_data c=%0d got %0d want %0d", c, bus.res_data, ex[c-3]); end
      end
      tick();
    end
    #1;
    vectors++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rr_drain valid=%b busy=%b want 0,0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    int     pa [4] = '{11, -22, 33, -44};
    int     pb [4] = '{5, 6, -7, 8};
    logic [39:0] held;
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, pa[i], pb[i]);
    for (int c = 0; c <= 9; c++) begin
      bus.req_valid = (c <= 5) ? 4'hF : 4'h0;
      bus.res_ready = !(c == 4 || c == 5);
      #1;
      if (c == 4 || c == 5) begin
        vectors++; if (bus.mul_ce !== 1'b0) begin errors++; $display("FAIL bp_ce c=%0d got %b want 0", c, bus.mul_ce); end
        vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got %b want 0000", c, bus.req_ready); end
      end
      if (c == 4) held = bus.res_data;
      if (c == 5) begin
        vectors++; if (bus.res_data !== held) begin errors++; $display("FAIL bp_stable got %0d want %0d", bus.res_data, held); end
      end
      if (c == 3 || c >= 4 && c <= 8) begin
        int id;
        id = (c <= 6) ? ((c == 3) ? 0 : 1) : c - 5;
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(id)) begin errors++; $display("FAIL bp_result c=%0d valid=%b id=%0d want 1,%0d", c, bus.res_valid, bus.res_id, id); end
        vectors++; if (bus.res_data !== 40'(longint'(pa[id]) * longint'(pb[id]))) begin errors++; $display("FAIL bp_data c=%0d got %0d want %0d", c, bus.res_data, pa[id] * pb[id]); end
      end
      if (c == 9) begin
        vectors++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_drain valid=%b busy=%b want 0,0", bus.res_valid, bus.busy); end
      end
      tick();
    end
    bus.res_ready = 1'b1;
  endtask

  task automatic test_extremes();
    int          xa [3] = '{-32768, 32767, -1};
    int          xb [3] = '{-8388608, 8388607, 1};
    logic [39:0] xr [3];
    xr[0] = 40'sd274877906944;
    xr[1] = 40'sd274869485569;
    xr[2] = 40'hFFFFFFFFFF;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c < 3) begin
        set_op(0, xa[c], xb[c]);
        bus.req_valid = 4'b0001;
      end else begin
        bus.req_valid = '0;
      end
      #1;
      if (c < 3) begin
        vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL ext_grant c=%0d got %b want 0001", c, bus.req_ready); end
      end else begin
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_data !== xr[c-3]) begin errors++; $display("FAIL ext_data c=%0d valid=%b got %h want %h", c, bus.res_valid, bus.res_data, xr[c-3]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(0, 9, 9);
    set_op(1, 4, 4);
    set_op(2, -7, 6);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    vectors++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset valid=%b busy=%b want 0,0", bus.res_valid, bus.busy); end
    vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", bus.req_ready); end
    tick();
    #1;
    vectors++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_second_grant got %b want 0100", bus.req_ready); end
    vectors++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", bus.res_valid); end
    tick();
    bus.req_valid = '0;
    #1;
    vectors++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_gap got %b want 0", bus.res_valid); end
    tick();
    #1;
    vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_data !== 40'sd81) begin errors++; $display("FAIL mid_res0 valid=%b id=%0d data=%0d want 1,0,81", bus.res_valid, bus.res_id, bus.res_data); end
    tick();
    #1;
    vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_data !== -40'sd42) begin errors++; $display("FAIL mid_res2 valid=%b id=%0d data=%0d want 1,2,-42", bus.res_valid, bus.res_id, bus.res_data); end
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] rv [5] = '{4'b1000, 4'b0101, 4'b0101, 4'b0100, 4'b0100};
    logic [3:0] gr [5] = '{4'b1000, 4'b0001, 4'b0100, 4'b0100, 4'b0100};
    int         ids [5] = '{3, 0, 2, 2, 2};
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10);
    for (int c = 0; c <= 7; c++) begin
      bus.req_valid = (c < 5) ? rv[c] : 4'b0000;
      #1;
      if (c < 5) begin
        vectors++; if (bus.req_ready !== gr[c]) begin errors++; $display("FAIL wrap_grant c=%0d got %b want %b", c, bus.req_ready, gr[c]); end
      end
      if (c >= 3) begin
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(ids[c-3]) || bus.res_data !== 40'((ids[c-3] + 1) * 10)) begin errors++; $display("FAIL wrap_result c=%0d valid=%b id=%0d data=%0d want 1,%0d,%0d", c, bus.res_valid, bus.res_id, bus.res_data, ids[c-3], (ids[c-3] + 1) * 10); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_single_data();
    test_round_robin();
    test_backpressure();
    test_extremes();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/gaussian_nb_mul_arbiter.md
Name: gaussian_nb_mul_arbiter

Overview:
Round-robin arbiter that shares one pipelined signed multiplier among NUM_REQ requesters in the Gaussian NB datapath. The multiplier computes 16s x 24s -> 40s and is clock-enable stalled. The arbiter accepts at most one operand pair per cycle and drives the multiplier operands and ce. It tracks each in-flight operation with a tag pipeline and returns every product on a shared result channel, tagged with the requester id. Result backpressure stalls the whole multiplier pipeline through ce.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, equal to clog2(NUM_REQ)
MUL_LATENCY, 3, ce-enabled clock edges from operands presented with mul_ce=1 to the matching product on mul_dout

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*16  signed din0 operands, requester i at bits [16i+15:16i]
req_b  in  NUM_REQ*24  signed din1 operands, requester i at bits [24i+23:24i]
mul_ce  out  1  multiplier clock enable
mul_din0  out  16  multiplier operand a
mul_din1  out  24  multiplier operand b
mul_dout  in  40  multiplier product
res_valid  out  1  result valid
res_ready  in  1  result accept
res_id  out  ID_W  requester that issued the result
res_data  out  40  signed product
busy  out  1  any operation in flight

Behaviour:
- Reset: clk and reset are fixed as above; reset is synchronous and active-high.
  - Clears all tag-pipeline valid bits and sets last_grant to NUM_REQ-1, so requester 0 has top priority.
  - After reset: res_valid=0, busy=0, res_id=0, res_data follows mul_dout (don't-care while res_valid=0).
- Stall:
  - mul_ce = ~(res_valid & ~res_ready), combinational.
  - While mul_ce=0: no grant, req_ready=0, the tag pipeline holds, and res_valid/res_id/res_data hold their values.
- Arbitration (combinational, only when mul_ce=1):
  - Scan from last_grant+1 upward modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner. req_ready depends on req_valid, which is permitted.
  - A handshake is req_valid[i] & req_ready[i]. On a handshake, last_grant <= i at the clock edge; otherwise last_grant holds.
- Operand mux:
  - mul_din0/mul_din1 = req_a/req_b slice of the winner, in the same cycle.
  - With no winner, both are driven to 0.
- Tag pipeline:
  - MUL_LATENCY stages of {valid, id}, advancing only on edges where mul_ce=1.
  - Stage 0 loads {handshake, winner id}.
  - res_valid = last-stage valid; res_id = last-stage id; res_data = mul_dout (no extra register).
- Latency: a handshake in cycle t gives res_valid in cycle t+MUL_LATENCY when there is no stall; each stall cycle adds one cycle.
- Throughput: one accept per cycle. Results return in accept order, and no result is dropped or duplicated.
- A result pops when res_valid & res_ready. The same cycle may also accept a new operand pair (mul_ce=1).
- busy = OR of all tag-stage valid bits.
- Reset mid-operation:
  - In-flight tags are discarded; no res_valid appears for them after reset.
  - Stale multiplier register contents are ignored because their tags are invalid.
- Arithmetic: full-precision signed 16x24 product, sign-extended to 40 bits; no saturation or rounding. The multiplier is external; the arbiter does not alter data.
- req_valid is held by the requester until its handshake. A request that drops before its handshake is simply never served.

Test Plan:
1. Single op: req_valid[0]=1, a=3, b=-5, res_ready=1 -> req_ready[0]=1 in cycle t; res_valid=1, res_id=0, res_data=-15 (0xFFFFFFFFF1) in cycle t+3; busy=1 for cycles t+1..t+3.
2. All four req_valid held high for 8 cycles with distinct operands -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; results arrive in that order with correct products, one per cycle.
3. Backpressure: result for id 1 is valid and res_ready=0 for 2 cycles -> mul_ce=0, req_ready=0, res_data/res_id stable; after res_ready=1, the stream resumes with no loss or duplication.
4. Extremes:
   - a=-32768, b=-8388608 -> res_data=274877906944.
   - a=32767, b=8388607 -> 274869485569.
   - a=-1, b=1 -> 0xFFFFFFFFFF.
5. Reset mid-operation: 2 ops in flight, reset for 1 cycle -> res_valid stays 0 and busy=0 the cycle after; next simultaneous req_valid on 0 and 2 grants requester 0 first.
6. Wrap-around: last grant to 3, then req_valid only on 2 and 0 -> 0 is granted, then 2; a lone requester stays granted every cycle.
